// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared definitions for the interrupt controller
//
// Purpose: FSM state encodings, the INTR_STATE enum and the cfg_addr register
// select constants used by intr_ctrl and its sub-module.
// Ports: none (package).

package intr_ctrl_pkg;

  // Raw encodings kept as plain constants so older code that compares against
  // bit patterns keeps working; the enum below is built on the same values.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REQ     = ST_REQ,
    SERVICE = ST_SERVICE
  } INTR_STATE;

  // cfg_addr register selects
  localparam logic [1:0] CFG_ADDR_MASK  = 2'd0;
  localparam logic [1:0] CFG_ADDR_PCLR  = 2'd1;
  localparam logic [1:0] CFG_ADDR_TIMER = 2'd2;

endpackage

// File: rtl/intr_sync_edge.sv
// rtl/intr_sync_edge.sv - two-flop synchronizer plus rising-edge detector
//
// Purpose: brings one asynchronous level-high interrupt line into the clk
// domain and produces a single-cycle pulse on each synchronized rising edge.
// Ports:
//   clk        input  clock
//   reset      input  synchronous, active-high reset
//   async_in   input  asynchronous interrupt line
//   rise       output one-cycle pulse, combinational from the synchronizer flops

module intr_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Left combinational so the pending register is the only detect-stage flop,
  // which keeps irq_in-to-irr at exactly four clocks.
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - fixed-priority vectored interrupt controller
//
// Purpose: synchronizes and edge-detects NSRC interrupt lines into a pending
// register, masks them, and runs an IDLE/REQ/SERVICE handshake with the
// execute stage. Optional periodic timer source on pending[0] when the macro
// INTR_TIMER_EN is defined; without it no timer logic exists.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   irq_in       asynchronous level-high device interrupt lines
//   icall_ack    execute stage took the interrupt call (pulse)
//   iret_ack     execute stage retired an iret (pulse)
//   cfg_we       configuration write strobe
//   cfg_addr     0 = mask, 1 = pending-clear, 2 = timer reload
//   cfg_wdata    configuration write data
//   irr          registered interrupt request
//   intr_vec     registered index of the requested / serviced source
//   busy         high while an interrupt is in service

module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int VW   = $clog2(NSRC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            icall_ack,
  input  logic            iret_ack,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [15:0]     cfg_wdata,
  output logic            irr,
  output logic [VW-1:0]   intr_vec,
  output logic            busy
);

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] set_vec, clr_vec, eligible;
  logic [VW-1:0]   sel_vec;
  logic            any_eligible;
  logic            take_call;
  logic            timer_set;
  INTR_STATE       state_q, state_d;
  logic            irr_q, irr_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            unused_cfg;

  assign unused_cfg = ^cfg_wdata;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    intr_sync_edge u_sync_edge (
      .clk      (clk),
      .reset    (reset),
      .async_in (irq_in[i]),
      .rise     (rise[i])
    );
  end

`ifdef INTR_TIMER_EN
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;

  // Counts reload, reload-1, ..., 0 and fires on 0, so the period is reload+1.
  always_comb begin
    reload_d  = reload_q;
    count_d   = count_q;
    timer_set = (reload_q != 16'd0) && (count_q == 16'd0);
    if (cfg_we && cfg_addr == CFG_ADDR_TIMER) begin
      reload_d = cfg_wdata;
      count_d  = cfg_wdata;
    end else if (reload_q != 16'd0) begin
      count_d = (count_q == 16'd0) ? reload_q : count_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= 16'd0;
      count_q  <= 16'd0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end
`else
  assign timer_set = 1'b0;
`endif

  assign take_call = (state_q == REQ) && icall_ack;

  // Pending / mask update; sets are ORed in last so they win over clears.
  always_comb begin
    set_vec    = rise;
    set_vec[0] = rise[0] | timer_set;
    clr_vec    = '0;
    if (cfg_we && cfg_addr == CFG_ADDR_PCLR) begin
      clr_vec = cfg_wdata[NSRC-1:0];
    end
    if (take_call) begin
      clr_vec[vec_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;

    mask_d = mask_q;
    if (cfg_we && cfg_addr == CFG_ADDR_MASK) begin
      mask_d = cfg_wdata[NSRC-1:0];
    end
  end

  // Fixed priority: scanning downward lets the lowest eligible index win.
  always_comb begin
    eligible     = pending_q & mask_q;
    any_eligible = |eligible;
    sel_vec      = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_vec = VW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    irr_d   = irr_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (any_eligible) begin
          state_d = REQ;
          irr_d   = 1'b1;
          vec_d   = sel_vec;
        end
      end
      REQ: begin
        if (icall_ack) begin
          // The vector presented this cycle is the one being called; freeze it.
          state_d = SERVICE;
          irr_d   = 1'b0;
          busy_d  = 1'b1;
        end else if (!any_eligible) begin
          state_d = IDLE;
          irr_d   = 1'b0;
        end else begin
          vec_d = sel_vec;
        end
      end
      SERVICE: begin
        if (iret_ack) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irr_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      state_q   <= IDLE;
      irr_q     <= 1'b0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      irr_q     <= irr_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
    end
  end

  assign irr      = irr_q;
  assign intr_vec = vec_q;
  assign busy     = busy_q;

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 8: number of external interrupt sources (2..16).
REQ-002 SHALL have parameter VW, default $clog2(NSRC): vector width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port irq_in  input  NSRC  asynchronous device interrupt lines, level-high.
REQ-006 SHALL have port icall_ack  input  1  one-cycle pulse when the execute stage performs an interrupt call.
REQ-007 SHALL have port iret_ack  input  1  one-cycle pulse when the execute stage retires an iret.
REQ-008 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-009 SHALL have port cfg_addr  input  2  register select: 0=mask, 1=pending-clear, 2=timer reload.
REQ-010 SHALL have port cfg_wdata  input  16  configuration write data.
REQ-011 SHALL have port irr  output  1  interrupt request to the status register, registered.
REQ-012 SHALL have port intr_vec  output  VW  index of the source being requested or serviced, registered.
REQ-013 SHALL have port busy  output  1  high while an interrupt is in service.

Function
REQ-014 SHALL pass each irq_in bit through a 2-flop synchronizer, then rising-edge detect it.
REQ-015 SHALL set pending[i] on a detected edge of source i; edges on already-pending bits are absorbed.
REQ-016 SHALL clear pending[i] on a write to addr 1 where cfg_wdata[i]=1, and on icall_ack for the vectored source.
REQ-017 SHALL give a same-cycle set priority over any clear of the same bit.
REQ-018 SHALL hold mask[NSRC-1:0]; a 1 enables a source; writes to addr 0 take effect next cycle.
REQ-019 SHALL select the eligible source (pending & mask) with the lowest index (fixed priority).
REQ-020 SHALL implement FSM states IDLE, REQ, SERVICE.
REQ-021 IDLE->REQ when any source is eligible; irr=1 and intr_vec=selected index from the next cycle.
REQ-022 In REQ, intr_vec SHALL track the highest-priority eligible source each cycle; REQ->IDLE if none remain eligible (masked or cleared).
REQ-023 REQ->SERVICE on icall_ack; intr_vec frozen, irr=0, busy=1 from the next cycle.
REQ-024 SERVICE->IDLE on iret_ack; no nesting; new edges during SERVICE only accumulate in pending.
REQ-025 SHALL ignore icall_ack outside REQ and iret_ack outside SERVICE.
REQ-026 Latency: edge on irq_in to irr high SHALL be exactly 4 cycles (2 sync, 1 detect, 1 FSM register).

Reset
REQ-027 On reset SHALL set irr=0, intr_vec=0, busy=0, pending=0, mask=0, synchronizers=0, state=IDLE, timer reload=0, timer count=0.
REQ-028 Reset asserted in any state SHALL return to IDLE the next cycle, discarding any in-service context.

Configuration
REQ-029 Macro INTR_TIMER_EN defined: 16-bit down counter; on a write to addr 2 it loads cfg_wdata and reloads the same value each time it reaches 0.
REQ-030 With INTR_TIMER_EN, the counter hitting 0 SHALL raise a set pulse ORed into pending[0]; a reload value of 0 disables the timer.
REQ-031 Without INTR_TIMER_EN, no timer logic SHALL be present; addr 2 writes are ignored.

Structure
REQ-032 The shared CPU package SHALL hold the state enum INTR_STATE and the constants for cfg_addr values.
REQ-033 The synchronizer and edge detector SHALL be one sub-module, intr_sync_edge, instantiated per source.

Verification
REQ-034 Scenario: mask=0xFF; pulse irq_in[3] at cycle 10 -> irr=1, intr_vec=3 at cycle 14.
REQ-035 Scenario: mask=0xFF; irq_in[5] and irq_in[2] rise together -> intr_vec=2; after icall_ack/iret_ack, intr_vec=5 is requested.
REQ-036 Scenario: mask=0x00, irq_in[1] edge -> irr stays 0; write mask=0x02 -> irr=1, intr_vec=1 one cycle later.
REQ-037 Scenario: in SERVICE, irq_in[0] edge -> no irr until iret_ack, then irr=1, intr_vec=0 the next cycle.
REQ-038 Scenario: pending-clear write of 0x08 while irq_in[3] edge is detected in the same cycle -> pending[3] stays 1.
REQ-039 Scenario (INTR_TIMER_EN): reload=4, mask=0x01 -> pending[0] set every 5 cycles; reset mid-SERVICE -> busy=0, irr=0 the next cycle.
